// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI mode-0 target port.
package spi_target_pkg;

  localparam int         BIT_CNT_W         = 3;
  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic frame_start;
    logic frame_end;
    logic rx_valid;
    logic tx_underrun;
  } evt_t;

endpackage

// File: rtl/spi_target_if.sv
// User-side bus of spi_target: RX strobe, TX holding-register handshake, frame events.
interface spi_target_if;
  import spi_target_pkg::*;

  // tx_data is transferred on any clock where tx_valid && tx_ready; tx_valid may
  // be held or dropped freely, tx_ready depends only on holding-register occupancy.
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       frame_start;
  logic       frame_end;
  logic       tx_underrun;
  state_t     state_dbg;

  modport slave (
    output rx_data, rx_valid, tx_ready, frame_start, frame_end, tx_underrun, state_dbg,
    input  tx_data, tx_valid
  );

  modport master (
    input  rx_data, rx_valid, tx_ready, frame_start, frame_end, tx_underrun, state_dbg,
    output tx_data, tx_valid
  );

endinterface

// File: rtl/spi_sync.sv
// N-stage flop synchronizer for one asynchronous pin, with a selectable reset level.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= {STAGES{RESET_VAL}};
    else          sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples the host pins on clk_48mhz, shifts bytes MSB first
// and exchanges them with user logic through a one-deep TX holding register.
module spi_target
  import spi_target_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_48mhz,
  input  logic        reset_n,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  spi_target_if.slave bus
);

  logic sck_s, cs_n_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk_48mhz), .reset_n(reset_n), .d(spi_sck), .q(sck_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
    .clk(clk_48mhz), .reset_n(reset_n), .d(spi_cs_n), .q(cs_n_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk_48mhz), .reset_n(reset_n), .d(spi_mosi), .q(mosi_s));

  logic                 sck_prev_q, sck_prev_d, cs_n_prev_q, cs_n_prev_d;
  logic                 sck_rise, sck_fall, cs_fall, cs_rise;
  state_t               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           rx_shift_q, rx_shift_d;
  logic [7:0]           tx_shift_q, tx_shift_d;
  logic [7:0]           hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  evt_t                 evt_q, evt_d;
  logic                 load, accept;
  logic                 miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic [7:0]           rx_data_q, rx_data_d;
  evt_t                 evt_out_q, evt_out_d;

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_n_s & cs_n_prev_q;
  assign cs_rise  = cs_n_s & ~cs_n_prev_q;

  // Chip-select changes win over any SCK edge in the same cycle, so the trailing
  // SCK fall that coincides with CS release does not pull in another byte.
  always_comb begin
    sck_prev_d  = sck_s;
    cs_n_prev_d = cs_n_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    evt_d       = '0;
    load        = 1'b0;
    accept      = bus.tx_valid & ~hold_full_q;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (cs_fall) begin
          state_d           = ST_SHIFT;
          evt_d.frame_start = 1'b1;
          load              = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d         = ST_IDLE;
          evt_d.frame_end = 1'b1;
          bit_cnt_d       = '0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == '1) evt_d.rx_valid = 1'b1;
        end else if (sck_fall) begin
          if (bit_cnt_q != '0) tx_shift_d = {tx_shift_q[6:0], 1'b0};
          else                 load       = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A load takes the old holding contents; a same-cycle accept refills it.
    if (load) begin
      tx_shift_d        = hold_full_q ? hold_q : IDLE_BYTE;
      evt_d.tx_underrun = ~hold_full_q;
      hold_full_d       = accept;
    end else if (accept) begin
      hold_full_d = 1'b1;
    end
    if (accept) hold_d = bus.tx_data;
  end

  always_comb begin
    miso_d    = (state_q == ST_SHIFT) ? tx_shift_q[7] : 1'b1;
    miso_oe_d = (state_q == ST_SHIFT);
    rx_data_d = evt_q.rx_valid ? rx_shift_q : rx_data_q;
    evt_out_d = evt_q;
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      sck_prev_q  <= 1'b0;
      cs_n_prev_q <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= IDLE_BYTE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      evt_q       <= '0;
      miso_q      <= 1'b1;
      miso_oe_q   <= 1'b0;
      rx_data_q   <= '0;
      evt_out_q   <= '0;
    end else begin
      sck_prev_q  <= sck_prev_d;
      cs_n_prev_q <= cs_n_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      evt_q       <= evt_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      rx_data_q   <= rx_data_d;
      evt_out_q   <= evt_out_d;
    end
  end

  assign spi_miso        = miso_q;
  assign spi_miso_oe     = miso_oe_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = evt_out_q.rx_valid;
  assign bus.tx_ready    = ~hold_full_q;
  assign bus.frame_start = evt_out_q.frame_start;
  assign bus.frame_end   = evt_out_q.frame_end;
  assign bus.tx_underrun = evt_out_q.tx_underrun;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: a mode-0 host model on the pins, a user-side
// feeder for the TX holding register, and a byte-level model of what the host should see.
module tb_spi_target;

  localparam int         SYNC_STAGES = 2;
  localparam logic [7:0] IDLE_BYTE   = 8'hFF;

  logic clk, reset_n, spi_sck, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe;
  spi_target_if bus();

  spi_target #(.IDLE_BYTE(IDLE_BYTE), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_48mhz(clk), .reset_n(reset_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .bus(bus));

  int tests_run = 0;
  int failed    = 0;
  int cyc       = 0;
  int n_rx = 0, n_us = 0, n_fs = 0, n_fe = 0;
  int d_rx, d_us, d_fs, d_fe;
  logic [7:0] host_mosi[$];
  logic [7:0] host_miso[$];
  logic [7:0] user_bytes[$];
  logic [7:0] feed_q[$];
  logic [7:0] rx_got[$];
  int         rx_cyc[$];
  int         rise_cyc[$];
  logic       rdy_prev;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- event monitor ----------------
  initial forever begin
    @(negedge clk);
    if (reset_n === 1'b1) begin
      if (bus.rx_valid === 1'b1) begin
        n_rx++;
        rx_got.push_back(bus.rx_data);
        rx_cyc.push_back(cyc);
      end
      if (bus.tx_underrun === 1'b1) n_us++;
      if (bus.frame_start === 1'b1) n_fs++;
      if (bus.frame_end === 1'b1)   n_fe++;
    end
  end

  // ---------------- user-side feeder ----------------
  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    rdy_prev     = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_valid && rdy_prev && feed_q.size() > 0) void'(feed_q.pop_front());
      bus.tx_valid = (feed_q.size() > 0);
      bus.tx_data  = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
      rdy_prev     = bus.tx_ready;
    end
  end

  // ---------------- reference model ----------------
  // Slot k of a frame carries the k-th byte the user offered, or IDLE_BYTE once they run out.
  function automatic logic [7:0] model_miso(input int k);
    return (k < user_bytes.size()) ? user_bytes[k] : IDLE_BYTE;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic host_frame(input int nbits, input int half, input bit release_cs);
    logic [7:0] cap;
    cap = '0;
    host_miso.delete();
    @(negedge clk);
    spi_cs_n = 1'b0;
    spi_mosi = host_mosi[0][7];
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      cap     = {cap[6:0], spi_miso};
      spi_sck = 1'b1;
      if (i % 8 == 7) begin
        host_miso.push_back(cap);
        rise_cyc.push_back(cyc);
      end
      repeat (half) @(negedge clk);
      spi_sck = 1'b0;
      if (i == nbits - 1) begin
        if (release_cs) spi_cs_n = 1'b1;
      end else begin
        spi_mosi = host_mosi[(i + 1) / 8][7 - ((i + 1) % 8)];
      end
      repeat (half) @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic do_frame(input int nbits, input int half, input bit release_cs,
                          output bit preload_ok);
    int s_rx, s_us, s_fs, s_fe;
    preload_ok = 1'b1;
    foreach (user_bytes[i]) feed_q.push_back(user_bytes[i]);
    if (user_bytes.size() > 0) begin
      preload_ok = 1'b0;
      for (int i = 0; i < 40 && !preload_ok; i++) begin
        @(negedge clk);
        if (bus.tx_ready === 1'b0) preload_ok = 1'b1;
      end
    end
    s_rx = n_rx; s_us = n_us; s_fs = n_fs; s_fe = n_fe;
    rx_got.delete(); rx_cyc.delete(); rise_cyc.delete();
    host_frame(nbits, half, release_cs);
    d_rx = n_rx - s_rx; d_us = n_us - s_us; d_fs = n_fs - s_fs; d_fe = n_fe - s_fe;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++; if (spi_miso !== 1'b1) begin failed++; $display("FAIL reset_miso got %b want 1", spi_miso); end
    tests_run++; if (spi_miso_oe !== 1'b0) begin failed++; $display("FAIL reset_oe got %b want 0", spi_miso_oe); end
    tests_run++; if (bus.rx_data !== 8'h00) begin failed++; $display("FAIL reset_rx_data got %h want 00", bus.rx_data); end
    tests_run++; if (bus.rx_valid !== 1'b0) begin failed++; $display("FAIL reset_rx_valid got %b want 0", bus.rx_valid); end
    tests_run++; if (bus.tx_ready !== 1'b1) begin failed++; $display("FAIL reset_tx_ready got %b want 1", bus.tx_ready); end
    tests_run++; if (bus.frame_start !== 1'b0 || bus.frame_end !== 1'b0 || bus.tx_underrun !== 1'b0) begin
      failed++; $display("FAIL reset_pulses got fs=%b fe=%b us=%b want 0", bus.frame_start, bus.frame_end, bus.tx_underrun);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    host_mosi.delete(); host_mosi.push_back(8'hA5);
    user_bytes.delete(); user_bytes.push_back(8'h3C);
    do_frame(8, 4, 1'b1, ok);
    tests_run++; if (ok !== 1'b1) begin failed++; $display("FAIL basic_preload timed out waiting for tx_ready=0"); end
    tests_run++; if (d_rx !== 1) begin failed++; $display("FAIL basic_rx_count got %0d want 1", d_rx); end
    tests_run++; if (rx_got.size() < 1 || rx_got[0] !== 8'hA5) begin
      failed++; $display("FAIL basic_rx_data got %h want a5", (rx_got.size() > 0) ? rx_got[0] : 8'hxx);
    end
    tests_run++; if (host_miso.size() < 1 || host_miso[0] !== model_miso(0)) begin
      failed++; $display("FAIL basic_miso got %h want %h", (host_miso.size() > 0) ? host_miso[0] : 8'hxx, model_miso(0));
    end
    tests_run++; if (d_us !== 0) begin failed++; $display("FAIL basic_underrun got %0d want 0", d_us); end
    tests_run++; if (d_fs !== 1 || d_fe !== 1) begin failed++; $display("FAIL basic_frame_pulses got fs=%0d fe=%0d want 1/1", d_fs, d_fe); end
    tests_run++; if (rx_cyc.size() < 1 || rise_cyc.size() < 1 || rx_cyc[0] - rise_cyc[0] !== SYNC_STAGES + 2) begin
      failed++; $display("FAIL basic_rx_latency got %0d want %0d",
                         (rx_cyc.size() > 0 && rise_cyc.size() > 0) ? rx_cyc[0] - rise_cyc[0] : -1, SYNC_STAGES + 2);
    end
  endtask

  task automatic test_underrun();
    bit ok;
    host_mosi.delete(); host_mosi.push_back(8'h9F); host_mosi.push_back(8'h00);
    user_bytes.delete(); user_bytes.push_back(8'hC2);
    do_frame(16, 4, 1'b1, ok);
    tests_run++; if (d_rx !== 2) begin failed++; $display("FAIL underrun_rx_count got %0d want 2", d_rx); end
    for (int k = 0; k < 2; k++) begin
      tests_run++; if (host_miso.size() <= k || host_miso[k] !== model_miso(k)) begin
        failed++; $display("FAIL underrun_miso[%0d] got %h want %h", k, (host_miso.size() > k) ? host_miso[k] : 8'hxx, model_miso(k));
      end
      tests_run++; if (rx_got.size() <= k || rx_got[k] !== host_mosi[k]) begin
        failed++; $display("FAIL underrun_rx[%0d] got %h want %h", k, (rx_got.size() > k) ? rx_got[k] : 8'hxx, host_mosi[k]);
      end
    end
    tests_run++; if (d_us !== 2 - user_bytes.size()) begin failed++; $display("FAIL underrun_count got %0d want 1", d_us); end
  endtask

  task automatic test_abort();
    bit ok;
    logic [7:0] kept;
    kept = 8'($urandom_range(0, 255));
    host_mosi.delete(); host_mosi.push_back(8'($urandom_range(0, 255)));
    user_bytes.delete(); user_bytes.push_back(8'h5A); user_bytes.push_back(kept);
    do_frame(5, 4, 1'b1, ok);
    tests_run++; if (d_fe !== 1) begin failed++; $display("FAIL abort_frame_end got %0d want 1", d_fe); end
    tests_run++; if (d_rx !== 0) begin failed++; $display("FAIL abort_rx_count got %0d want 0", d_rx); end
    tests_run++; if (spi_miso_oe !== 1'b0) begin failed++; $display("FAIL abort_oe got %b want 0", spi_miso_oe); end
    tests_run++; if (bus.tx_ready !== 1'b0) begin failed++; $display("FAIL abort_hold_kept tx_ready got %b want 0", bus.tx_ready); end
    host_mosi.delete(); host_mosi.push_back(8'h81);
    user_bytes.delete();
    do_frame(8, 4, 1'b1, ok);
    tests_run++; if (rx_got.size() < 1 || rx_got[0] !== 8'h81 || d_rx !== 1) begin
      failed++; $display("FAIL abort_next_rx got %h (count %0d) want 81 (count 1)", (rx_got.size() > 0) ? rx_got[0] : 8'hxx, d_rx);
    end
    tests_run++; if (host_miso.size() < 1 || host_miso[0] !== kept || d_us !== 0) begin
      failed++; $display("FAIL abort_next_miso got %h us=%0d want %h us=0", (host_miso.size() > 0) ? host_miso[0] : 8'hxx, d_us, kept);
    end
  endtask

  task automatic test_cs_high();
    int s_rx, s_fs, oe_bad;
    s_rx = n_rx; s_fs = n_fs; oe_bad = 0;
    spi_cs_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      spi_sck  = ~spi_sck;
      spi_mosi = 1'($urandom_range(0, 1));
      repeat (4) begin
        @(negedge clk);
        if (spi_miso_oe !== 1'b0) oe_bad++;
      end
    end
    spi_sck = 1'b0;
    repeat (6) @(negedge clk);
    tests_run++; if (oe_bad !== 0) begin failed++; $display("FAIL cs_high_oe got %0d cycles high want 0", oe_bad); end
    tests_run++; if (n_rx - s_rx !== 0) begin failed++; $display("FAIL cs_high_rx got %0d want 0", n_rx - s_rx); end
    tests_run++; if (n_fs - s_fs !== 0) begin failed++; $display("FAIL cs_high_frame_start got %0d want 0", n_fs - s_fs); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    host_mosi.delete(); user_bytes.delete();
    for (int k = 0; k < 4; k++) begin
      host_mosi.push_back(8'($urandom_range(0, 255)));
      user_bytes.push_back(8'(k + 1));
    end
    do_frame(32, 4, 1'b1, ok);
    for (int k = 0; k < 4; k++) begin
      tests_run++; if (host_miso.size() <= k || host_miso[k] !== model_miso(k)) begin
        failed++; $display("FAIL b2b_miso[%0d] got %h want %h", k, (host_miso.size() > k) ? host_miso[k] : 8'hxx, model_miso(k));
      end
      tests_run++; if (rx_got.size() <= k || rx_got[k] !== host_mosi[k]) begin
        failed++; $display("FAIL b2b_rx[%0d] got %h want %h", k, (rx_got.size() > k) ? rx_got[k] : 8'hxx, host_mosi[k]);
      end
    end
    tests_run++; if (d_us !== 0) begin failed++; $display("FAIL b2b_underrun got %0d want 0", d_us); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int s_rx;
    logic [7:0] b;
    feed_q.push_back(8'hAB);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.tx_ready === 1'b0) ok = 1'b1;
    end
    tests_run++; if (ok !== 1'b1) begin failed++; $display("FAIL midrst_preload timed out waiting for tx_ready=0"); end
    s_rx = n_rx;
    host_mosi.delete(); host_mosi.push_back(8'($urandom_range(0, 255)));
    host_frame(3, 4, 1'b0);
    reset_n  = 1'b0;
    spi_cs_n = 1'b1;
    @(negedge clk);
    tests_run++; if (spi_miso !== 1'b1 || spi_miso_oe !== 1'b0) begin
      failed++; $display("FAIL midrst_pins got miso=%b oe=%b want 1/0", spi_miso, spi_miso_oe);
    end
    tests_run++; if (bus.rx_data !== 8'h00 || bus.rx_valid !== 1'b0) begin
      failed++; $display("FAIL midrst_rx got %h/%b want 00/0", bus.rx_data, bus.rx_valid);
    end
    tests_run++; if (bus.tx_ready !== 1'b1) begin failed++; $display("FAIL midrst_tx_ready got %b want 1", bus.tx_ready); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    tests_run++; if (n_rx - s_rx !== 0) begin failed++; $display("FAIL midrst_no_rx got %0d want 0", n_rx - s_rx); end
    b = 8'($urandom_range(0, 255));
    host_mosi.delete(); host_mosi.push_back(b);
    user_bytes.delete();
    do_frame(8, 4, 1'b1, ok);
    tests_run++; if (rx_got.size() < 1 || rx_got[0] !== b || d_rx !== 1) begin
      failed++; $display("FAIL midrst_clean_rx got %h (count %0d) want %h (count 1)", (rx_got.size() > 0) ? rx_got[0] : 8'hxx, d_rx, b);
    end
    tests_run++; if (host_miso.size() < 1 || host_miso[0] !== model_miso(0) || d_us !== 1) begin
      failed++; $display("FAIL midrst_clean_miso got %h us=%0d want %h us=1", (host_miso.size() > 0) ? host_miso[0] : 8'hxx, d_us, model_miso(0));
    end
  endtask

  task automatic test_random();
    bit ok;
    int nbytes, c, half;
    for (int it = 0; it < 8; it++) begin
      nbytes = $urandom_range(1, 3);
      c      = $urandom_range(0, nbytes);
      half   = $urandom_range(4, 6);
      host_mosi.delete(); user_bytes.delete();
      for (int k = 0; k < nbytes; k++) host_mosi.push_back(8'($urandom_range(0, 255)));
      for (int k = 0; k < c; k++)      user_bytes.push_back(8'($urandom_range(0, 254)));
      do_frame(8 * nbytes, half, 1'b1, ok);
      tests_run++; if (ok !== 1'b1 || d_rx !== nbytes) begin
        failed++; $display("FAIL rand%0d_rx_count got %0d (preload %b) want %0d", it, d_rx, ok, nbytes);
      end
      tests_run++; if (d_us !== nbytes - c) begin failed++; $display("FAIL rand%0d_underrun got %0d want %0d", it, d_us, nbytes - c); end
      for (int k = 0; k < nbytes; k++) begin
        tests_run++; if (rx_got.size() <= k || rx_got[k] !== host_mosi[k]) begin
          failed++; $display("FAIL rand%0d_rx[%0d] got %h want %h", it, k, (rx_got.size() > k) ? rx_got[k] : 8'hxx, host_mosi[k]);
        end
        tests_run++; if (host_miso.size() <= k || host_miso[k] !== model_miso(k)) begin
          failed++; $display("FAIL rand%0d_miso[%0d] got %h want %h", it, k, (host_miso.size() > k) ? host_miso[k] : 8'hxx, model_miso(k));
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_abort();
    test_cs_high();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/spi_target.md
# spi_target

SPI mode-0 target (peripheral) port for the iCE40 fabric: the responder at the opposite end of the SPI link from the bootloader's flash master, letting an external host MCU exchange bytes with user logic. Runs entirely on `clk_48mhz`, oversampling the asynchronous SPI pins. Exposes a byte-wide receive strobe and a one-deep transmit holding register with valid/ready handshake. Sits between the `pin_SPI_*`-style pads (via SB_IO, tristate MISO) and user logic.

## Interface
- `IDLE_BYTE`, 8'hFF: byte shifted out when no transmit byte is queued.
- `SYNC_STAGES`, 2: synchronizer depth for `spi_sck`, `spi_cs_n`, `spi_mosi`; legal range 2..3.
- `clk_48mhz`  in  1  system clock, 48 MHz.
- `reset_n`  in  1  synchronous, active-low reset.
- `spi_sck`  in  1  SPI clock from host, asynchronous, idle low.
- `spi_cs_n`  in  1  chip select from host, active low, asynchronous.
- `spi_mosi`  in  1  host-to-target data, asynchronous.
- `spi_miso`  out  1  target-to-host data.
- `spi_miso_oe`  out  1  output enable for the MISO SB_IO; high only while selected.
- `rx_data`  out  8  last received byte, MSB first on wire.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` valid that cycle.
- `tx_data`  in  8  next byte to transmit.
- `tx_valid`  in  1  `tx_data` offered.
- `tx_ready`  out  1  holding register empty; transfer when `tx_valid && tx_ready`.
- `frame_start`  out  1  one-cycle pulse on synchronized CS assertion.
- `frame_end`  out  1  one-cycle pulse on synchronized CS deassertion.
- `tx_underrun`  out  1  one-cycle pulse when `IDLE_BYTE` is loaded because holding register was empty.

## Operation
- Synchronize SCK/CS_n/MOSI through `SYNC_STAGES` flops; one further register gives previous value for edge detection (rise/fall of SCK, fall/rise of CS_n).
- States: IDLE, SHIFT.
  - IDLE: `spi_miso_oe`=0, bit counter=0. On CS fall → SHIFT, pulse `frame_start`, load TX shift register from holding register if full (clear it), else `IDLE_BYTE` with `tx_underrun` pulse; `spi_miso` = bit 7 immediately.
  - SHIFT: SCK rise → shift synchronized MOSI into RX shift register LSB, counter+1 (3-bit, wraps 7→0). On wrap: `rx_data` ← completed byte, `rx_valid` pulse. SCK fall → if counter≠0, shift TX register left, drive new bit 7; if counter=0 (byte boundary), load next byte from holding register or `IDLE_BYTE` (with `tx_underrun`). The first SCK fall of a frame (counter=1) is a normal shift.
  - CS rise in SHIFT → IDLE, `frame_end` pulse, partial RX byte discarded (no `rx_valid`), counter cleared; holding register contents retained.
- SCK edges while CS deasserted are ignored. CS fall and SCK edge in same synchronized cycle: CS handled, SCK edge ignored.
- Holding register accepts `tx_valid && tx_ready` any cycle; if a load into the shift register occurs in the same cycle as an accept, the shift register takes the old holding contents (or `IDLE_BYTE` if empty) and the new byte is stored, `tx_ready` stays 0.
- Reset (`reset_n`=0 at a clock edge): all outputs to reset values, state IDLE, holding register emptied, regardless of frame in progress.

## Timing
- Reset values: `spi_miso`=1, `spi_miso_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_ready`=1, `frame_start`=`frame_end`=`tx_underrun`=0.
- Pin-to-action latency: `SYNC_STAGES`+1 clocks from a pin edge to the state update; outputs registered, one more clock to the pin.
- `rx_valid` asserts `SYNC_STAGES`+2 clocks after the 8th SCK rising edge.
- Max SCK = `clk_48mhz`/8 (6 MHz), each SCK phase ≥4 clocks; CS_n setup to first SCK rise ≥4 clocks.
- User must refill the holding register before the byte-boundary SCK fall to avoid underrun: ≥7 SCK periods after `tx_ready` rises.

## Structure
- Package `spi_target_pkg`: state encoding (IDLE/SHIFT), `IDLE_BYTE` default, bit-count width constant.
- Sub-module `spi_sync`: parameterized N-stage synchronizer, instanced for SCK, CS_n, MOSI.

## Test plan
- Reset mid-frame after 3 bits → outputs at reset values next cycle, no `rx_valid`, `tx_ready`=1, next frame starts clean.
- Host sends 8'hA5 with holding register loaded 8'h3C → `rx_data`=8'hA5 with one `rx_valid`; host captures 8'h3C; no `tx_underrun`.
- Two-byte frame 8'h9F,8'h00 with only one tx byte 8'hC2 queued → host reads 8'hC2,8'hFF; one `tx_underrun` at byte boundary; two `rx_valid`.
- CS released after 5 bits → `frame_end` pulse, no `rx_valid`, `spi_miso_oe`=0; next frame receives 8'h81 correctly.
- SCK toggling with CS_n high → no `rx_valid`, no `frame_start`, `spi_miso_oe`=0 throughout.
- Back-to-back 4-byte frame at 6 MHz, user refilling on each `tx_ready` with 8'h01..8'h04 → host reads 8'h01..8'h04, zero underruns.
